psum_deskew_collector: RTL and testbench

- Sits at the bottom edge of the weight-stationary systolic array, at the receiving end of the array's skewed output stream.
- Captures per-column partial sums, which are skewed by one cycle per column, and realigns them into complete output rows.
- Adds the configured bias and streams rows to the output writer over a valid/ready interface.
- Counts rows per tile (A_rows) and flags tile completion and overflow.

---
 rtl/psum_deskew_collector_pkg.sv | 18 +
 rtl/psum_deskew_collector_if.sv | 43 ++++
 rtl/psum_deskew_collector_lane_store.sv | 102 ++++++++++
 rtl/psum_deskew_collector.sv | 159 +++++++++++++++
 tb/tb_psum_deskew_collector.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/psum_deskew_collector_pkg.sv
// -----------------------------------------------------------------------------
// psum_deskew_collector_pkg
// Shared configuration for the systolic-array output path: array geometry,
// partial-sum width, tile height, bias and output buffer depth, plus the
// partial-sum element and row types.
// -----------------------------------------------------------------------------
package psum_deskew_collector_pkg;

  localparam int sys_cols            = 2;   // array columns / result lanes
  localparam int P_BITWIDTH          = 24;  // partial-sum width
  localparam int A_rows              = 4;   // rows per output tile
  localparam int BIAS                = 0;   // bias added to every lane
  localparam int output_buffer_depth = 16;  // deskew buffer row slots

  typedef logic [P_BITWIDTH-1:0] psum_t;
  typedef psum_t [sys_cols-1:0]  psum_row_t;

endpackage

// File: rtl/psum_deskew_collector_if.sv
// -----------------------------------------------------------------------------
// psum_deskew_collector_if
// Bus between the array bottom edge, the deskew collector and the output
// writer.
//   psum_i / psum_valid_i : per-column partial sums, column j lags j-1 by one
//   out_data_o            : deskewed row, lane j in bits [j*P_W +: P_W]
//   out_valid_o/out_ready_i : row handshake
//   out_last_o            : current row closes the tile
// Modports: master = array feeder + consumer side, slave = collector.
// -----------------------------------------------------------------------------
interface psum_deskew_collector_if
  import psum_deskew_collector_pkg::*;
#(
  parameter int SYS_COLS = sys_cols,
  parameter int P_W      = P_BITWIDTH
);

  logic [SYS_COLS-1:0][P_W-1:0] psum_i;
  logic [SYS_COLS-1:0]          psum_valid_i;
  logic [SYS_COLS*P_W-1:0]      out_data_o;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic                         out_last_o;

  modport master (
    output psum_i,
    output psum_valid_i,
    output out_ready_i,
    input  out_data_o,
    input  out_valid_o,
    input  out_last_o
  );

  modport slave (
    input  psum_i,
    input  psum_valid_i,
    input  out_ready_i,
    output out_data_o,
    output out_valid_o,
    output out_last_o
  );

endinterface

// File: rtl/psum_deskew_collector_lane_store.sv
// -----------------------------------------------------------------------------
// psum_lane_store
// Storage for one array column: DEPTH data slots, a written bit per slot and
// a write pointer that wraps modulo 2*DEPTH.
//   clk, rst_n, clear_i : clock, async reset, synchronous flush
//   wr_en, wr_data      : column write request and value
//   rd_slot, free_en    : slot presented to the reader, release it this edge
//   look_slot           : slot whose post-edge written bit is reported
//   rd_data             : stored value of rd_slot
//   look_wbit           : written bit of look_slot as it will be after the edge
//   wr_hit              : write request landed on an occupied slot (dropped)
//   wp_nxt              : write pointer as it will be after the edge
// -----------------------------------------------------------------------------
module psum_lane_store
  import psum_deskew_collector_pkg::*;
#(
  parameter int P_W   = P_BITWIDTH,
  parameter int DEPTH = output_buffer_depth,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          wr_en,
  input  logic [P_W-1:0] wr_data,
  input  logic [AW-1:0] rd_slot,
  input  logic          free_en,
  input  logic [AW-1:0] look_slot,
  output logic [P_W-1:0] rd_data,
  output logic          look_wbit,
  output logic          wr_hit,
  output logic [AW:0]   wp_nxt
);

  localparam logic [AW:0] one_c = (AW+1)'(1);

  logic [P_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0] wbit_r;
  logic [AW:0]      wp_r;
  logic [AW-1:0]    wr_slot_s;
  logic             wr_ok_s;

  // Write acceptance, next pointer and the post-edge view of look_slot.
  // A slot being freed this edge is still occupied for a same-edge write,
  // so such a write is reported as a hit rather than accepted.
  always_comb begin
    wr_slot_s = wp_r[AW-1:0];
    wr_ok_s   = 1'b0;
    wr_hit    = 1'b0;
    wp_nxt    = wp_r;
    look_wbit = 1'b0;
    if (clear_i) begin
      wp_nxt = '0;
    end else begin
      wr_ok_s = wr_en & ~wbit_r[wr_slot_s];
      wr_hit  = wr_en &  wbit_r[wr_slot_s];
      if (wr_ok_s) begin
        wp_nxt = wp_r + one_c;
      end else begin
        wp_nxt = wp_r;
      end
      look_wbit = (wbit_r[look_slot] & ~(free_en & (look_slot == rd_slot)))
                | (wr_ok_s & (look_slot == wr_slot_s));
    end
  end

  // Write pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_r <= '0;
    end else begin
      wp_r <= wp_nxt;
    end
  end

  // Written bits: set on an accepted write, cleared when the reader frees
  // the slot; both may happen on different slots in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbit_r <= '0;
    end else if (clear_i) begin
      wbit_r <= '0;
    end else begin
      if (free_en) begin
        wbit_r[rd_slot] <= 1'b0;
      end
      if (wr_ok_s) begin
        wbit_r[wr_slot_s] <= 1'b1;
      end
    end
  end

  // Data slots; contents survive reset and flush by design.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_slot_s] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_slot];

endmodule

// File: rtl/psum_deskew_collector.sv
// -----------------------------------------------------------------------------
// psum_deskew_collector
// Realigns the skewed per-column partial sums leaving the systolic array into
// whole rows, adds the bias and streams rows over valid/ready. Tracks rows
// per tile, raises almost-full toward the feeder and flags overflow.
//   clk, rst_n     : clock, asynchronous active-low reset
//   clear_i        : synchronous flush of pointers, counters and flags
//   bus (slave)    : psum input lanes and row output handshake
//   almost_full_o  : free slots <= AF_MARGIN
//   overflow_o     : sticky, a column write hit an occupied slot
//   tile_done_o    : one-cycle pulse after the tile's last row is accepted
// -----------------------------------------------------------------------------
module psum_deskew_collector
  import psum_deskew_collector_pkg::*;
#(
  parameter int SYS_COLS  = sys_cols,
  parameter int P_W       = P_BITWIDTH,
  parameter int DEPTH     = output_buffer_depth,
  parameter int TILE_ROWS = A_rows,
  parameter int BIAS_VAL  = BIAS,
  parameter int AF_MARGIN = SYS_COLS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  psum_deskew_collector_if.slave bus,
  output logic almost_full_o,
  output logic overflow_o,
  output logic tile_done_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int RCW = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

  localparam logic [AW:0]     one_c       = (AW+1)'(1);
  localparam logic [AW:0]     depth_c     = (AW+1)'(DEPTH);
  localparam logic [AW:0]     af_margin_c = (AW+1)'(AF_MARGIN);
  localparam logic [RCW-1:0]  row_one_c   = RCW'(1);
  localparam logic [RCW-1:0]  last_row_c  = RCW'(TILE_ROWS - 1);
  localparam logic [P_W-1:0]  bias_c      = P_W'(BIAS_VAL);

  logic [AW:0]     rp_r;
  logic [RCW-1:0]  row_cnt_r;
  logic            out_valid_r;
  logic            out_last_r;
  logic            almost_full_r;
  logic            overflow_r;
  logic            tile_done_r;

  logic [AW:0]     rp_nxt_s;
  logic [RCW-1:0]  row_cnt_nxt_s;
  logic            xfer_s;
  logic            free_en_s;
  logic [AW:0]     occ_nxt_s;
  logic [AW:0]     free_nxt_s;
  logic            valid_nxt_s;
  logic            last_nxt_s;
  logic            af_nxt_s;
  logic            done_nxt_s;
  logic            ovf_nxt_s;

  logic [P_W-1:0]          lane_data_s [SYS_COLS];
  logic [AW:0]             wp_nxt_s    [SYS_COLS];
  logic [SYS_COLS-1:0]     look_wbit_s;
  logic [SYS_COLS-1:0]     wr_hit_s;
  logic [SYS_COLS*P_W-1:0] out_data_s;

  assign free_en_s = xfer_s & ~clear_i;

  // One independent store per column; all read the same row slot rp.
  for (genvar j = 0; j < SYS_COLS; j++) begin : g_lane
    psum_lane_store #(
      .P_W   (P_W),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (clear_i),
      .wr_en     (bus.psum_valid_i[j]),
      .wr_data   (bus.psum_i[j]),
      .rd_slot   (rp_r[AW-1:0]),
      .free_en   (free_en_s),
      .look_slot (rp_nxt_s[AW-1:0]),
      .rd_data   (lane_data_s[j]),
      .look_wbit (look_wbit_s[j]),
      .wr_hit    (wr_hit_s[j]),
      .wp_nxt    (wp_nxt_s[j])
    );
  end

  // Next-state of the read side. Status outputs are computed from the
  // post-edge pointers and written bits so that the registered valid rises
  // the cycle right after the last lane of a row lands.
  always_comb begin
    xfer_s        = out_valid_r & bus.out_ready_i;
    rp_nxt_s      = rp_r;
    row_cnt_nxt_s = row_cnt_r;
    if (clear_i) begin
      rp_nxt_s      = '0;
      row_cnt_nxt_s = '0;
    end else if (xfer_s) begin
      rp_nxt_s = rp_r + one_c;
      if (row_cnt_r == last_row_c) begin
        row_cnt_nxt_s = '0;
      end else begin
        row_cnt_nxt_s = row_cnt_r + row_one_c;
      end
    end else begin
      rp_nxt_s      = rp_r;
      row_cnt_nxt_s = row_cnt_r;
    end
    // Column 0 leads the skew, so its pointer defines occupancy.
    occ_nxt_s   = wp_nxt_s[0] - rp_nxt_s;
    free_nxt_s  = depth_c - occ_nxt_s;
    valid_nxt_s = &look_wbit_s;
    last_nxt_s  = valid_nxt_s & (row_cnt_nxt_s == last_row_c);
    af_nxt_s    = (free_nxt_s <= af_margin_c);
    done_nxt_s  = xfer_s & out_last_r & ~clear_i;
    ovf_nxt_s   = clear_i ? 1'b0 : (overflow_r | (|wr_hit_s));
  end

  // Read pointer, tile row counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp_r          <= '0;
      row_cnt_r     <= '0;
      out_valid_r   <= 1'b0;
      out_last_r    <= 1'b0;
      almost_full_r <= 1'b0;
      overflow_r    <= 1'b0;
      tile_done_r   <= 1'b0;
    end else begin
      rp_r          <= rp_nxt_s;
      row_cnt_r     <= row_cnt_nxt_s;
      out_valid_r   <= valid_nxt_s;
      out_last_r    <= last_nxt_s;
      almost_full_r <= af_nxt_s;
      overflow_r    <= ovf_nxt_s;
      tile_done_r   <= done_nxt_s;
    end
  end

  // Bias add on the presented slot; modulo wrap at P_W bits.
  always_comb begin
    out_data_s = '0;
    for (int j = 0; j < SYS_COLS; j++) begin
      out_data_s[j*P_W +: P_W] = lane_data_s[j] + bias_c;
    end
  end

  assign bus.out_data_o  = out_data_s;
  assign bus.out_valid_o = out_valid_r;
  assign bus.out_last_o  = out_last_r;
  assign almost_full_o   = almost_full_r;
  assign overflow_o      = overflow_r;
  assign tile_done_o     = tile_done_r;

endmodule

// File: tb/tb_psum_deskew_collector.sv
// -----------------------------------------------------------------------------
// tb_psum_deskew_collector
// Directed bench for psum_deskew_collector: skewed streams, backpressure,
// fill/overflow, bias wrap, simultaneous read/write, reset and flush.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_psum_deskew_collector;
  import psum_deskew_collector_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic clear_i;
  logic af, ovf, done;
  logic b_af, b_ovf, b_done;

  always #5 clk = ~clk;

  psum_deskew_collector_if dif ();
  psum_deskew_collector_if bif ();

  psum_deskew_collector dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (clear_i),
    .bus           (dif),
    .almost_full_o (af),
    .overflow_o    (ovf),
    .tile_done_o   (done)
  );

  psum_deskew_collector #(.BIAS_VAL(1)) dut_bias (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (clear_i),
    .bus           (bif),
    .almost_full_o (b_af),
    .overflow_o    (b_ovf),
    .tile_done_o   (b_done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  psum_row_t exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive the inputs for the coming edge and score what is visible.
  task automatic cycle(input logic v0, input logic [23:0] d0,
                       input logic v1, input logic [23:0] d1, input logic rdy);
    @(negedge clk);
    dif.psum_valid_i = {v1, v0};
    dif.psum_i[0]    = d0;
    dif.psum_i[1]    = d1;
    dif.out_ready_i  = rdy;
    if (done) begin
      done_cnt++;
      check("done_pos", 64'(xfer_cnt % 4), 64'(0));
    end
    if (dif.out_valid_o) begin
      if (exp_q.size() == 0) begin
        check("row_unexpected", 64'(dif.out_valid_o), 64'(0));
      end else begin
        check(rdy ? "row_data" : "row_hold", 64'(dif.out_data_o), 64'(exp_q[0]));
        check("row_last", 64'(dif.out_last_o), 64'(xfer_cnt % 4 == 3));
        if (rdy) begin
          void'(exp_q.pop_front());
          xfer_cnt++;
        end
      end
    end else begin
      check("idle_last", 64'(dif.out_last_o), 64'(0));
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 24'd0, 1'b0, 24'd0, rdy);
  endtask

  // Skewed stream of n rows: row r = {lane0 = base+r, lane1 = (base+r)*10}.
  task automatic push_stream(input int n, input int base, input int rdy_start);
    for (int k = 0; k <= n; k++) begin
      psum_row_t r;
      if (k < n) begin
        r[0] = 24'(base + k);
        r[1] = 24'((base + k) * 10);
        exp_q.push_back(r);
      end
      cycle(k < n, 24'(base + k), k >= 1, 24'((base + k - 1) * 10), k >= rdy_start);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    psum_row_t r;
    rst_n   = 1'b0;
    clear_i = 1'b0;
    dif.psum_valid_i = '0; dif.psum_i = '0; dif.out_ready_i = 1'b0;
    bif.psum_valid_i = '0; bif.psum_i = '0; bif.out_ready_i = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_valid", 64'(dif.out_valid_o), 64'(0));
    check("rst_last",  64'(dif.out_last_o),  64'(0));
    check("rst_af",    64'(af),   64'(0));
    check("rst_ovf",   64'(ovf),  64'(0));
    check("rst_done",  64'(done), 64'(0));
    rst_n = 1'b1;

    // Bias wrap on the BIAS_VAL=1 instance.
    @(negedge clk);
    bif.psum_valid_i = 2'b11; bif.psum_i[0] = 24'hFFFFFF; bif.psum_i[1] = 24'hFFFFFF;
    @(negedge clk);
    check("bias_valid", 64'(bif.out_valid_o), 64'(1));
    check("bias_wrap",  64'(bif.out_data_o),  64'(0));
    bif.psum_i[0] = 24'd5; bif.psum_i[1] = 24'd7; bif.out_ready_i = 1'b1;
    @(negedge clk);
    check("bias_add", 64'(bif.out_data_o), {16'd0, 24'd8, 24'd6});
    check("bias_ovf", 64'(b_ovf), 64'(0));
    check("bias_af",  64'(b_af),  64'(0));
    check("bias_done", 64'(b_done), 64'(0));
    bif.psum_valid_i = 2'b00; bif.out_ready_i = 1'b0;

    // Skewed stream with ready=1, latency of the first row.
    for (int i = 1; i <= 4; i++) begin
      r[0] = 24'(i); r[1] = 24'(i * 10); exp_q.push_back(r);
    end
    cycle(1'b1, 24'd1, 1'b0, 24'd0, 1'b1);
    check("lat_k0", 64'(dif.out_valid_o), 64'(0));
    cycle(1'b1, 24'd2, 1'b1, 24'd10, 1'b1);
    check("lat_k1", 64'(dif.out_valid_o), 64'(0));
    cycle(1'b1, 24'd3, 1'b1, 24'd20, 1'b1);
    check("lat_k2_xfer", 64'(xfer_cnt), 64'(1));
    cycle(1'b1, 24'd4, 1'b1, 24'd30, 1'b1);
    cycle(1'b0, 24'd0, 1'b1, 24'd40, 1'b1);
    idle(3, 1'b1);
    check("s1_rows", 64'(xfer_cnt), 64'(4));
    check("s1_done", 64'(done_cnt), 64'(1));
    check("s1_empty", 64'(exp_q.size()), 64'(0));

    // Backpressure: ready low for 10 cycles.
    push_stream(4, 5, 99);
    idle(5, 1'b0);
    check("bp_valid", 64'(dif.out_valid_o), 64'(1));
    check("bp_data", 64'(dif.out_data_o), {16'd0, 24'd50, 24'd5});
    idle(6, 1'b1);
    check("bp_rows", 64'(xfer_cnt), 64'(8));
    check("bp_done", 64'(done_cnt), 64'(2));
    check("bp_empty", 64'(exp_q.size()), 64'(0));

    // Fill to 16 rows, almost-full threshold, then overflow.
    push_stream(13, 20, 99);
    idle(1, 1'b0);
    check("af_occ13", 64'(af), 64'(0));
    push_stream(1, 33, 99);
    idle(1, 1'b0);
    check("af_occ14", 64'(af), 64'(1));
    push_stream(2, 34, 99);
    idle(1, 1'b0);
    check("full_ovf0", 64'(ovf), 64'(0));
    cycle(1'b1, 24'd99, 1'b0, 24'd0, 1'b0);
    idle(1, 1'b0);
    check("ovf_set", 64'(ovf), 64'(1));
    check("ovf_slot0", 64'(dif.out_data_o), {16'd0, 24'd200, 24'd20});

    // Flush with a simultaneous write and ready; flush must win.
    exp_q.delete();
    @(negedge clk);
    clear_i = 1'b1;
    dif.psum_valid_i = 2'b11; dif.psum_i[0] = 24'd55; dif.psum_i[1] = 24'd550;
    dif.out_ready_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    dif.psum_valid_i = 2'b00; dif.out_ready_i = 1'b0;
    check("clr_ovf",   64'(ovf), 64'(0));
    check("clr_valid", 64'(dif.out_valid_o), 64'(0));
    check("clr_af",    64'(af), 64'(0));
    xfer_cnt = 0;
    push_stream(4, 60, 0);
    idle(3, 1'b1);
    check("clr_rows", 64'(xfer_cnt), 64'(4));
    check("clr_done", 64'(done_cnt), 64'(3));

    // Row transfer and a column-0 write in the same cycle at occ=DEPTH-1.
    push_stream(15, 70, 99);
    idle(1, 1'b0);
    check("rw_af15", 64'(af), 64'(1));
    cycle(1'b1, 24'd90, 1'b0, 24'd0, 1'b1);
    r[0] = 24'd90; r[1] = 24'd900; exp_q.push_back(r);
    cycle(1'b0, 24'd0, 1'b1, 24'd900, 1'b0);
    check("rw_ovf", 64'(ovf), 64'(0));
    check("rw_af_hold", 64'(af), 64'(1));
    idle(20, 1'b1);
    check("rw_empty", 64'(exp_q.size()), 64'(0));
    check("rw_rows", 64'(xfer_cnt), 64'(20));
    check("rw_af_drained", 64'(af), 64'(0));
    check("rw_done", 64'(done_cnt), 64'(7));

    // Reset in the middle of a tile with a row pending.
    push_stream(2, 100, 0);
    cycle(1'b1, 24'd102, 1'b0, 24'd0, 1'b0);
    idle(1, 1'b0);
    check("pre_rst_valid", 64'(dif.out_valid_o), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(dif.out_valid_o), 64'(0));
    check("mid_rst_last",  64'(dif.out_last_o),  64'(0));
    check("mid_rst_af",    64'(af),   64'(0));
    check("mid_rst_ovf",   64'(ovf),  64'(0));
    check("mid_rst_done",  64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    xfer_cnt = 0;
    push_stream(4, 110, 0);
    idle(3, 1'b1);
    check("rst_rows", 64'(xfer_cnt), 64'(4));
    check("rst_done_cnt", 64'(done_cnt), 64'(8));
    check("rst_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
